// File: rtl/lock_pkg.sv
//------------------------------------------------------------------------------
// lock_pkg : shared types and constants for the keypad lock sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lock_pkg;

  localparam int DIGITS = 4;

  typedef logic [3:0]  digit_t;
  typedef logic [15:0] code_t;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ENTRY        = 3'd1,
    S_OPEN         = 3'd2,
    S_LOCKOUT      = 3'd3,
    S_PROG_NEW     = 3'd4,
    S_PROG_CONFIRM = 3'd5
  } lock_state_t;

  function automatic logic is_digit(input digit_t k);
    return k < 4'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_collector.sv
//------------------------------------------------------------------------------
// digit_collector : BCD shift register with digit count and idle timeout
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module digit_collector
  import lock_pkg::*;
#(
  parameter int DIGIT_TIMEOUT = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear_i,
  input  logic   valid_i,
  input  digit_t key_i,
  output code_t  value_o,
  output logic   full_o,
  output logic   timeout_o
);

  localparam int              c_idle_w    = $clog2(DIGIT_TIMEOUT + 1);
  localparam logic [2:0]      c_last_slot = 3'(DIGITS - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(DIGIT_TIMEOUT - 1);

  logic [11:0]         shift_q;
  logic [2:0]          count_q;
  logic [c_idle_w-1:0] idle_q;

  // Full and timeout are combinational so the FSM acts on the sampling edge.
  assign value_o   = {shift_q, key_i};
  assign full_o    = valid_i && (count_q == c_last_slot);
  assign timeout_o = !valid_i && (idle_q == c_idle_last);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      shift_q <= '0;
      count_q <= '0;
      idle_q  <= '0;
    end else if (valid_i) begin
      shift_q <= {shift_q[7:0], key_i};
      count_q <= count_q + 3'd1;
      idle_q  <= '0;
    end else if (!timeout_o) begin
      idle_q  <= idle_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lock_sequencer.sv
//------------------------------------------------------------------------------
// lock_sequencer : keypad door-lock controller with lockout and code programming
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lock_sequencer
  import lock_pkg::*;
#(
  parameter int OPEN_CYCLES    = 9,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int DIGIT_TIMEOUT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key,
  input  logic                          pressed,
  input  logic                          enter_prog,
  output logic                          unlocked,
  output logic                          locked_out,
  output logic                          prog_active,
  output logic                          code_set,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int c_fail_w  = $clog2(MAX_FAIL + 1);
  localparam int c_tmr_max = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
  localparam logic [c_tmr_w-1:0]  c_open_last = c_tmr_w'(OPEN_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]  c_lock_last = c_tmr_w'(LOCKOUT_CYCLES - 1);
  localparam logic [c_fail_w-1:0] c_fail_max  = c_fail_w'(MAX_FAIL);

  lock_state_t         state_q, state_d;
  code_t               code_q, code_d;
  code_t               cand_q, cand_d;
  logic [c_fail_w-1:0] fail_q, fail_d;
  logic [c_tmr_w-1:0]  tmr_q, tmr_d;
  logic                code_set_q, code_set_d;
  logic                unlocked_q, locked_out_q, prog_active_q;

  logic  w_key_ok, w_prog_ok, w_col_valid, w_col_clear;
  logic  w_full, w_timeout;
  code_t w_entry;

  assign w_key_ok  = pressed && is_digit(key);
  assign w_prog_ok = enter_prog &&
                     (((state_q == S_IDLE) && !code_set_q) || (state_q == S_OPEN));

  // A legal enter_prog swallows a simultaneous digit.
  assign w_col_valid = w_key_ok && !w_prog_ok &&
                       ((state_q == S_IDLE) || (state_q == S_ENTRY) ||
                        (state_q == S_PROG_NEW) || (state_q == S_PROG_CONFIRM));

  // The collector is already empty in IDLE, so IDLE->ENTRY keeps the first digit.
  assign w_col_clear = (state_d != state_q) &&
                       !((state_q == S_IDLE) && (state_d == S_ENTRY));

  digit_collector #(
    .DIGIT_TIMEOUT (DIGIT_TIMEOUT)
  ) u_collector (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (w_col_clear),
    .valid_i   (w_col_valid),
    .key_i     (key),
    .value_o   (w_entry),
    .full_o    (w_full),
    .timeout_o (w_timeout)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cand_d     = cand_q;
    fail_d     = fail_q;
    code_set_d = code_set_q;
    tmr_d      = tmr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (w_prog_ok)        state_d = S_PROG_NEW;
        else if (w_col_valid) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (w_full) begin
          if (!code_set_q) begin
            state_d = S_IDLE;
          end else if (w_entry == code_q) begin
            state_d = S_OPEN;
            fail_d  = '0;
          end else begin
            fail_d  = fail_q + 1'b1;
            state_d = (fail_d == c_fail_max) ? S_LOCKOUT : S_IDLE;
          end
        end else if (w_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (w_prog_ok)                 state_d = S_PROG_NEW;
        else if (tmr_q == c_open_last) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (tmr_q == c_lock_last) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end
      S_PROG_NEW: begin
        if (w_full) begin
          cand_d  = w_entry;
          state_d = S_PROG_CONFIRM;
        end else if (w_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_PROG_CONFIRM: begin
        if (w_full) begin
          if (w_entry == cand_q) begin
            code_d     = w_entry;
            code_set_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (w_timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      code_q         <= '0;
      cand_q         <= '0;
      fail_q         <= '0;
      tmr_q          <= '0;
      code_set_q     <= 1'b0;
      unlocked_q     <= 1'b0;
      locked_out_q   <= 1'b0;
      prog_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      cand_q         <= cand_d;
      fail_q         <= fail_d;
      tmr_q          <= tmr_d;
      code_set_q     <= code_set_d;
      unlocked_q     <= (state_d == S_OPEN);
      locked_out_q   <= (state_d == S_LOCKOUT);
      prog_active_q  <= (state_d == S_PROG_NEW) || (state_d == S_PROG_CONFIRM);
    end
  end

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign prog_active = prog_active_q;
  assign code_set    = code_set_q;
  assign fail_count  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_sequencer.sv
//------------------------------------------------------------------------------
// tb_lock_sequencer : directed self-checking bench for lock_sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       pressed;
  logic       enter_prog;
  logic       unlocked;
  logic       locked_out;
  logic       prog_active;
  logic       code_set;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lock_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .pressed     (pressed),
    .enter_prog  (enter_prog),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_active (prog_active),
    .code_set    (code_set),
    .fail_count  (fail_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic press(input logic [3:0] d);
    key = d; pressed = 1'b1;
    @(negedge clk);
    pressed = 1'b0; key = 4'd0;
  endtask

  task automatic code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
  endtask

  task automatic prog();
    enter_prog = 1'b1;
    @(negedge clk);
    enter_prog = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_run(input string tag);
    int cnt;
    cnt = 0;
    while (unlocked && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, cnt, 9);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlocked"},   unlocked,    0);
    check({tag, "_locked_out"}, locked_out,  0);
    check({tag, "_prog"},       prog_active, 0);
    check({tag, "_code_set"},   code_set,    0);
    check({tag, "_fail"},       fail_count,  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lo_cnt;
    logic saw_unl;
    rst_n = 1'b0; pressed = 1'b0; enter_prog = 1'b0; key = 4'd0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Program 1234 from reset
    prog();
    check("prog_new_active", prog_active, 1);
    code(16'h1234);
    check("prog_confirm_active", prog_active, 1);
    check("code_set_pending", code_set, 0);
    code(16'h1234);
    check("code_set", code_set, 1);
    check("prog_done", prog_active, 0);
    prog();
    check("prog_refused_when_set", prog_active, 0);

    code(16'h1234);
    check("unlock_1234", unlocked, 1);
    open_run("open_len");

    // Wrong code then right code
    code(16'h1235);
    check("wrong_no_unlock", unlocked, 0);
    check("wrong_fail1", fail_count, 1);
    code(16'h1234);
    check("right_unlock", unlocked, 1);
    check("right_fail0", fail_count, 0);
    open_run("open_len2");

    // Lockout after three wrong codes; keypad ignored during it
    code(16'h1111);
    code(16'h2222);
    check("fail2", fail_count, 2);
    code(16'h3333);
    check("lockout_rise", locked_out, 1);
    check("lockout_fail3", fail_count, 3);
    lo_cnt = 0; saw_unl = 1'b0;
    while (locked_out && lo_cnt < 200) begin
      lo_cnt++;
      saw_unl |= unlocked;
      if (lo_cnt == 30) check("lockout_fail_hold", fail_count, 3);
      if (lo_cnt >= 10 && lo_cnt < 14) begin
        key = 4'(lo_cnt - 9); pressed = 1'b1;
      end else begin
        pressed = 1'b0;
      end
      @(negedge clk);
    end
    pressed = 1'b0;
    check("lockout_len", lo_cnt, 64);
    check("lockout_ignored_code", saw_unl, 0);
    check("lockout_fail_clear", fail_count, 0);
    code(16'h1234);
    check("post_lockout_unlock", unlocked, 1);
    open_run("open_len3");

    // Partial entry abandoned after 32 idle cycles
    code(16'h1235);
    press(4'd1); press(4'd2);
    idle(32);
    check("timeout_fail_kept", fail_count, 1);
    code(16'h1234);
    check("timeout_then_unlock", unlocked, 1);
    check("timeout_fail_clear", fail_count, 0);
    open_run("open_len4");

    // 31 idle cycles is not yet a timeout
    press(4'd1); press(4'd2);
    idle(31);
    press(4'd3); press(4'd4);
    check("no_timeout_31", unlocked, 1);
    open_run("open_len5");

    // Out-of-range key mid-entry is ignored
    press(4'd1); press(4'd2); press(4'd12); press(4'd3); press(4'd4);
    check("bad_key_ignored", unlocked, 1);
    open_run("open_len6");

    // Failed confirm keeps 1234
    code(16'h1234);
    prog();
    check("prog_drops_unlock", unlocked, 0);
    check("prog_from_open", prog_active, 1);
    code(16'h5678);
    code(16'h5679);
    check("bad_confirm_exit", prog_active, 0);
    check("bad_confirm_code_set", code_set, 1);
    code(16'h1234);
    check("old_code_kept", unlocked, 1);

    // Matching confirm replaces it with 5678
    prog();
    code(16'h5678);
    code(16'h5678);
    check("reprog_exit", prog_active, 0);
    code(16'h1234);
    check("old_code_rejected", unlocked, 0);
    check("old_code_fail", fail_count, 1);
    code(16'h5678);
    check("new_code_unlock", unlocked, 1);
    check("new_code_fail0", fail_count, 0);

    // Reset while open
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("mid_open_reset");
    code(16'h1234);
    check("no_code_after_reset", unlocked, 0);
    check("no_code_fail", fail_count, 0);
    code(16'h0000);
    check("zero_code_after_reset", unlocked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
